jtframe_pocket_inputs: RTL and testbench
========================================

JTFRAME_POCKET_INPUTS -- requirements
Module: jtframe_pocket_inputs

Interface
REQ-001 SHALL have parameter PLAYERS, default 2: number of Pocket controllers mapped, legal range 1..4.
REQ-002 SHALL have parameter BUTTONS, default 2: game buttons per player, legal range 1..6.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 means all digital game outputs are active-low.
REQ-004 SHALL have parameter COIN_FRAMES, default 3: minimum coin pulse length, in frames.
REQ-005 SHALL have parameter AF_FRAMES, default 4: autofire half-period, in frames.
REQ-006 SHALL have parameter DEADZONE, default 8: analog dead-zone magnitude.
REQ-007 SHALL have port clk, input, 1 bit: the only clock.
REQ-008 SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-009 SHALL have port vs, input, 1 bit: game vertical sync; its rising edge defines one frame.
REQ-010 SHALL have port cont_key, input, PLAYERS*16 bits: Pocket key words, player 1 in the LSBs.
REQ-011 SHALL have port cont_joy, input, PLAYERS*32 bits: Pocket analog words; bits [7:0] are X and [15:8] are Y, unsigned, 0x80 is centre.
REQ-012 SHALL have port af_en, input, PLAYERS bits: per-player autofire enable.
REQ-013 SHALL have port game_joystick, output, PLAYERS*10 bits: per player, bit0 right, bit1 left, bit2 down, bit3 up, bits4-9 buttons 1-6.
REQ-014 SHALL have port game_coin, output, PLAYERS bits: coin input per player.
REQ-015 SHALL have port game_start, output, PLAYERS bits: start input per player.
REQ-016 SHALL have port game_service, output, 1 bit: service input.
REQ-017 SHALL have port joyana, output, PLAYERS*16 bits: per player {Y,X}, each signed 8-bit.

Function
REQ-018 SHALL map key bits as follows: 0 up, 1 down, 2 left, 3 right, 4 A to button 1, 5 B to button 2, 6 X to button 3, 7 Y to button 4, 8 L1 to button 5, 9 R1 to button 6, 14 select to coin, 15 start to start.
REQ-019 SHALL register directions, buttons and start with exactly one clk of latency from cont_key.
REQ-020 SHALL force buttons above BUTTONS, and all players at index PLAYERS and above, to inactive.
REQ-021 SHALL invert every digital output when ACTIVE_LOW=1, including the reset values.
REQ-022 SHALL detect a frame tick on the vs rising edge (vs registered, then current & ~previous), and only on that edge.
REQ-023 SHALL run a per-player coin FSM: IDLE -> PULSE on the select rising edge; PULSE -> HOLD when COIN_FRAMES ticks have elapsed; HOLD -> IDLE when select is low.
REQ-024 SHALL assert coin during PULSE only, giving a one-shot per press that ignores a held key.
REQ-025 SHALL keep the coin pulse running to completion if select is released during PULSE.
REQ-026 SHALL NOT start a new pulse when select rises again while the FSM is still in PULSE.
REQ-027 SHALL assert game_service while player 1 holds start and select together; in that condition player 1's start and coin outputs SHALL be inactive.
REQ-028 SHALL compute the analog value as (raw XOR 0x80) interpreted as a signed 8-bit number.
REQ-029 SHALL output 0 for any analog value whose magnitude is <= DEADZONE, and pass all other values through unchanged.
REQ-030 SHALL register the analog outputs with one clk of latency.

Reset
REQ-031 SHALL, while rst=1, clear all FSMs to IDLE and clear the frame counters and the vs history.
REQ-032 SHALL hold all digital outputs inactive and joyana at 0 while rst=1.
REQ-033 SHALL treat a key already held when rst is released as a new edge (coin FSM goes IDLE -> PULSE).
REQ-034 SHALL abort a coin pulse that is in progress when rst asserts.

Configuration
REQ-035 SHALL implement autofire only when macro JTFRAME_POCKET_AUTOFIRE_EN is defined.
REQ-036 SHALL, with the macro defined and af_en[p]=1 while A is held, toggle button 1 every AF_FRAMES ticks, starting active.
REQ-037 SHALL reset the player's autofire counter when A is released.
REQ-038 SHALL, without the macro, ignore af_en and add no autofire logic.

Structure
REQ-039 SHALL place the Pocket key bit-index constants and the coin FSM state typedef in package jtframe_pocket_pkg.
REQ-040 SHALL implement the coin FSM and its frame counter in sub-module jtframe_pocket_coin, instantiated once per player.

Verification
REQ-041 SHALL verify direction mapping: P1 cont_key=0x0009 (up+right) -> game_joystick[3:0]=4'b0110 one clk later, with ACTIVE_LOW=1.
REQ-042 SHALL verify coin one-shot: select held for 10 frames with COIN_FRAMES=3 -> game_coin[0] active for exactly 3 vs edges, then inactive until select is released and pressed again.
REQ-043 SHALL verify the short-press boundary: select high for 1 clk, then re-pressed during PULSE -> exactly one 3-frame pulse.
REQ-044 SHALL verify analog dead-zone: raw X=0x85 -> joyana X=0; raw X=0x40 -> 0xC0 (-64); raw X=0xFF -> 0x7F.
REQ-045 SHALL verify service: P1 start+select held -> game_service active, game_start[0] and game_coin[0] inactive.
REQ-046 SHALL verify autofire (macro defined, AF_FRAMES=4): A held 16 frames -> button 1 pattern on-4, off-4, on-4, off-4; rst asserted mid-pulse -> all outputs inactive the next clk.

Source files
------------

// File: rtl/jtframe_pocket_pkg.sv
// Shared Pocket key-word bit positions, coin FSM state type and analog dead-zone helper.
// Pure declarations; no clocked logic.
package jtframe_pocket_pkg;

    localparam int KEY_UP     = 0;
    localparam int KEY_DOWN   = 1;
    localparam int KEY_LEFT   = 2;
    localparam int KEY_RIGHT  = 3;
    localparam int KEY_A      = 4;
    localparam int KEY_B      = 5;
    localparam int KEY_X      = 6;
    localparam int KEY_Y      = 7;
    localparam int KEY_L1     = 8;
    localparam int KEY_R1     = 9;
    localparam int KEY_SELECT = 14;
    localparam int KEY_START  = 15;

    typedef enum logic [1:0] {
        COIN_IDLE  = 2'd0,
        COIN_PULSE = 2'd1,
        COIN_HOLD  = 2'd2
    } coin_st_t;

    // Offset-binary raw sample to signed, zeroed when |value| <= dz.
    function automatic logic [7:0] ana_dz(input logic [7:0] raw, input logic [7:0] dz);
        logic [8:0] s9;
        logic [8:0] mag;
        s9     = {~raw[7], ~raw[7], raw[6:0]};
        mag    = s9[8] ? (~s9 + 9'd1) : s9;
        ana_dz = (mag <= {1'b0, dz}) ? 8'd0 : s9[7:0];
    endfunction

endpackage

// File: rtl/jtframe_pocket_coin.sv
// One-shot coin pulse of COIN_FRAMES frames per select press; output is a state decode.
// No backpressure: a held key parks the FSM in HOLD until released.
module jtframe_pocket_coin
    import jtframe_pocket_pkg::*;
#(
    parameter int COIN_FRAMES = 3
)(
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sel,
    output logic coin
);

    localparam int CW = $clog2(COIN_FRAMES + 1);
    localparam logic [CW-1:0] LAST = CW'(COIN_FRAMES - 1);

    coin_st_t        st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sel_q;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        case (st_q)
            COIN_IDLE: begin
                if (sel && !sel_q) begin
                    st_d  = COIN_PULSE;
                    cnt_d = '0;
                end
            end
            // Select is deliberately ignored here: the pulse always runs to completion.
            COIN_PULSE: begin
                if (tick) begin
                    if (cnt_q == LAST) st_d  = COIN_HOLD;
                    else               cnt_d = cnt_q + CW'(1);
                end
            end
            COIN_HOLD: begin
                if (!sel) st_d = COIN_IDLE;
            end
            default: st_d = COIN_IDLE;
        endcase
    end

    // sel_q clears in reset so a key held across reset release counts as a new press.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= COIN_IDLE;
            cnt_q <= '0;
            sel_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            sel_q <= sel;
        end
    end

    assign coin = (st_q == COIN_PULSE);

endmodule

// File: rtl/jtframe_pocket_inputs.sv
// Maps Pocket controller words to arcade joystick/coin/start/service and dead-zoned analog; one clk latency.
// No backpressure. Autofire on button 1 exists only with JTFRAME_POCKET_AUTOFIRE_EN defined.
module jtframe_pocket_inputs
    import jtframe_pocket_pkg::*;
#(
    parameter int PLAYERS     = 2,
    parameter int BUTTONS     = 2,
    parameter int ACTIVE_LOW  = 1,
    parameter int COIN_FRAMES = 3,
    parameter int AF_FRAMES   = 4,
    parameter int DEADZONE    = 8
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vs,
    input  logic [PLAYERS*16-1:0] cont_key,
    input  logic [PLAYERS*32-1:0] cont_joy,
    input  logic [PLAYERS-1:0]    af_en,
    output logic [PLAYERS*10-1:0] game_joystick,
    output logic [PLAYERS-1:0]    game_coin,
    output logic [PLAYERS-1:0]    game_start,
    output logic                  game_service,
    output logic [PLAYERS*16-1:0] joyana
);

    localparam logic       INV      = (ACTIVE_LOW != 0);
    localparam logic [5:0] BTN_EN   = 6'((1 << BUTTONS) - 1);
    localparam logic [9:0] JOY_MASK = {BTN_EN, 4'hF};
    localparam logic [7:0] DZ       = 8'(DEADZONE);

    logic               vs_q, tick;
    logic               svc_d, svc_q;
    logic [PLAYERS-1:0] coin_pulse;

    assign tick  = vs & ~vs_q;
    assign svc_d = cont_key[KEY_START] & cont_key[KEY_SELECT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q  <= 1'b0;
            svc_q <= 1'b0;
        end else begin
            vs_q  <= vs;
            svc_q <= svc_d;
        end
    end

    assign game_service = svc_q ^ INV;

`ifndef JTFRAME_POCKET_AUTOFIRE_EN
    logic unused_af;
    assign unused_af = ^af_en;
`endif

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        localparam logic IS_P1 = (p == 0);

        logic [15:0] key;
        logic [9:0]  joy_d, joy_q;
        logic [15:0] ana_d, ana_q;
        logic        btn1, start_d, start_q;
        logic        unused_bits;

        assign key         = cont_key[p*16 +: 16];
        assign unused_bits = ^{key[13:10], cont_joy[p*32+16 +: 16]};

`ifdef JTFRAME_POCKET_AUTOFIRE_EN
        localparam int            AFW     = $clog2(AF_FRAMES + 1);
        localparam logic [AFW-1:0] AF_LAST = AFW'(AF_FRAMES - 1);

        logic [AFW-1:0] af_cnt_q;
        logic           af_ph_q;

        // Phase restarts active on every fresh press of A.
        always_ff @(posedge clk) begin
            if (rst || !key[KEY_A]) begin
                af_cnt_q <= '0;
                af_ph_q  <= 1'b1;
            end else if (tick) begin
                if (af_cnt_q == AF_LAST) begin
                    af_cnt_q <= '0;
                    af_ph_q  <= ~af_ph_q;
                end else begin
                    af_cnt_q <= af_cnt_q + AFW'(1);
                end
            end
        end

        assign btn1 = key[KEY_A] & (~af_en[p] | af_ph_q);
`else
        assign btn1 = key[KEY_A];
`endif

        assign joy_d   = {key[KEY_R1], key[KEY_L1], key[KEY_Y], key[KEY_X], key[KEY_B], btn1,
                          key[KEY_UP], key[KEY_DOWN], key[KEY_LEFT], key[KEY_RIGHT]} & JOY_MASK;
        assign start_d = key[KEY_START] & ~(IS_P1 & svc_d);
        assign ana_d   = {ana_dz(cont_joy[p*32+8 +: 8], DZ), ana_dz(cont_joy[p*32 +: 8], DZ)};

        always_ff @(posedge clk) begin
            if (rst) begin
                joy_q   <= '0;
                start_q <= 1'b0;
                ana_q   <= '0;
            end else begin
                joy_q   <= joy_d;
                start_q <= start_d;
                ana_q   <= ana_d;
            end
        end

        jtframe_pocket_coin #(
            .COIN_FRAMES (COIN_FRAMES)
        ) u_coin (
            .clk  (clk),
            .rst  (rst),
            .tick (tick),
            .sel  (key[KEY_SELECT]),
            .coin (coin_pulse[p])
        );

        assign game_joystick[p*10 +: 10] = joy_q ^ {10{INV}};
        assign game_start[p]             = start_q ^ INV;
        assign game_coin[p]              = (coin_pulse[p] & ~(IS_P1 & svc_q)) ^ INV;
        assign joyana[p*16 +: 16]        = ana_q;
    end

endmodule

// File: tb/tb_jtframe_pocket_inputs.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_jtframe_pocket_inputs;

    localparam int PLAYERS     = 2;
    localparam int BUTTONS     = 4;
    localparam int COIN_FRAMES = 3;
    localparam int AF_FRAMES   = 4;
    localparam int DEADZONE    = 8;
    localparam int FRAME       = 6;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  vs  = 1'b0;
    logic [PLAYERS*16-1:0] cont_key = '0;
    logic [PLAYERS*32-1:0] cont_joy = {PLAYERS{32'h0000_8080}};
    logic [PLAYERS-1:0]    af_en = '0;
    logic [PLAYERS*10-1:0] game_joystick;
    logic [PLAYERS-1:0]    game_coin;
    logic [PLAYERS-1:0]    game_start;
    logic                  game_service;
    logic [PLAYERS*16-1:0] joyana;

    always #5 clk = ~clk;

    jtframe_pocket_inputs #(
        .PLAYERS     (PLAYERS),
        .BUTTONS     (BUTTONS),
        .ACTIVE_LOW  (1),
        .COIN_FRAMES (COIN_FRAMES),
        .AF_FRAMES   (AF_FRAMES),
        .DEADZONE    (DEADZONE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vs            (vs),
        .cont_key      (cont_key),
        .cont_joy      (cont_joy),
        .af_en         (af_en),
        .game_joystick (game_joystick),
        .game_coin     (game_coin),
        .game_start    (game_start),
        .game_service  (game_service),
        .joyana        (joyana)
    );

    typedef struct packed {
        logic [PLAYERS*10-1:0] joy;
        logic [PLAYERS-1:0]    coin;
        logic [PLAYERS-1:0]    start;
        logic                  svc;
        logic [PLAYERS*16-1:0] ana;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   vs_rand  = 0;

    // Reference model state: frames left in the current coin pulse, waiting-for-release flag, ticks since A pressed.
    bit m_prev_vs;
    bit m_prev_sel [PLAYERS];
    int m_rem      [PLAYERS];
    bit m_needrel  [PLAYERS];
    int m_af       [PLAYERS];

    function automatic logic [7:0] ref_ana(input logic [7:0] raw);
        int v;
        v = int'(raw) - 128;
        if (v >= -DEADZONE && v <= DEADZONE) return 8'd0;
        return 8'(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    task automatic model_push();
        exp_t        e;
        bit          tick, svc;
        logic [15:0] k;
        logic [9:0]  j;
        e = '0;
        if (rst) begin
            m_prev_vs = 0;
            for (int p = 0; p < PLAYERS; p++) begin
                m_prev_sel[p] = 0;
                m_rem[p]      = 0;
                m_needrel[p]  = 0;
                m_af[p]       = 0;
            end
        end else begin
            tick      = vs && !m_prev_vs;
            m_prev_vs = vs;
            svc       = cont_key[15] && cont_key[14];
            e.svc     = svc;
            for (int p = 0; p < PLAYERS; p++) begin
                k    = cont_key[p*16 +: 16];
                j    = '0;
                j[0] = k[3];
                j[1] = k[2];
                j[2] = k[1];
                j[3] = k[0];
                for (int b = 0; b < 6; b++)
                    if (b < BUTTONS) j[4+b] = k[4+b];
`ifdef JTFRAME_POCKET_AUTOFIRE_EN
                if (k[4] && af_en[p]) j[4] = ((m_af[p] / AF_FRAMES) % 2) == 0;
                if (k[4]) begin
                    if (tick) m_af[p]++;
                end else begin
                    m_af[p] = 0;
                end
`endif
                e.joy[p*10 +: 10] = j;
                e.start[p] = k[15] && !(p == 0 && svc);
                if (m_rem[p] > 0) begin
                    if (tick) begin
                        m_rem[p]--;
                        if (m_rem[p] == 0) m_needrel[p] = 1;
                    end
                end else if (m_needrel[p]) begin
                    if (!k[14]) m_needrel[p] = 0;
                end else if (k[14] && !m_prev_sel[p]) begin
                    m_rem[p] = COIN_FRAMES;
                end
                m_prev_sel[p] = k[14];
                e.coin[p] = (m_rem[p] > 0) && !(p == 0 && svc);
                e.ana[p*16 +: 16] = {ref_ana(cont_joy[p*32+8 +: 8]), ref_ana(cont_joy[p*32 +: 8])};
            end
        end
        e.joy   = ~e.joy;
        e.coin  = ~e.coin;
        e.start = ~e.start;
        e.svc   = ~e.svc;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            if (vs_rand) vs = ($urandom_range(0, 2) == 0);
            else         vs = ((cyc % FRAME) < 2);
            model_push();
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("joystick", 64'(game_joystick), 64'(mon_e.joy));
            chk("coin",     64'(game_coin),     64'(mon_e.coin));
            chk("start",    64'(game_start),    64'(mon_e.start));
            chk("service",  64'(game_service),  64'(mon_e.svc));
            chk("joyana",   64'(joyana),        64'(mon_e.ana));
        end
    end

    logic [7:0] ana_tab [10] = '{8'h85, 8'h40, 8'hFF, 8'h80, 8'h88, 8'h89, 8'h78, 8'h77, 8'h00, 8'h01};

    initial begin
        rst      = 1'b1;
        cont_key = 32'hC0F3_C0FF;
        step(4);
        rst      = 1'b0;
        cont_key = '0;
        step(3);

        // Up+right on player 1, then every button on both players.
        cont_key = 32'h0000_0009;
        step(2);
        cont_key = 32'h83F5_03FA;
        step(2);
        cont_key = '0;
        step(2);

        // Select held ten frames, released, pressed again.
        cont_key = 32'h4000_4000;
        step(10 * FRAME);
        cont_key = '0;
        step(2 * FRAME);
        cont_key = 32'h0000_4000;
        step(5 * FRAME);
        cont_key = '0;
        step(FRAME);

        // One-clk press then re-press inside the pulse.
        cont_key = 32'h0000_4000;
        step(1);
        cont_key = '0;
        step(2);
        cont_key = 32'h0000_4000;
        step(1);
        cont_key = '0;
        step(5 * FRAME);

        // Service combo.
        cont_key = 32'h8000_C000;
        step(2 * FRAME);
        cont_key = '0;
        step(FRAME);

        // Analog dead-zone table.
        for (int i = 0; i < 10; i++) begin
            cont_joy = {8'h00, 8'h00, ana_tab[9-i], ana_tab[i], 8'h00, 8'h00, ~ana_tab[i], ana_tab[i]};
            step(1);
        end
        cont_joy = {PLAYERS{32'h0000_8080}};

        // Reset mid-pulse with select still held across reset release.
        cont_key = 32'h0000_4000;
        step(FRAME + 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(4 * FRAME);
        cont_key = '0;
        step(FRAME);

        // Autofire: A held 16 frames, reset mid-run.
        af_en    = 2'b11;
        cont_key = 32'h0010_0010;
        step(16 * FRAME);
        cont_key = '0;
        step(2);
        cont_key = 32'h0010_0010;
        step(5 * FRAME + 2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(3 * FRAME);
        cont_key = '0;
        af_en    = '0;
        step(FRAME);

        // Randomised traffic, including random vs and occasional reset.
        vs_rand = 1;
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) cont_key = $urandom;
            if ($urandom_range(0, 31) == 0) af_en = 2'($urandom);
            cont_joy = {$urandom, $urandom};
            step(1);
        end
        vs_rand  = 0;
        rst      = 1'b0;
        cont_key = '0;
        step(3);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
